// File: rtl/interrupt_request_ctrl.sv
// ---------------------------------------------------------------------------
// interrupt_request_ctrl
// Initiator side of the processor interrupt handshake. Edge-detects up to
// N_SRC peripheral request lines, latches them as pending, arbitrates the
// unmasked ones by fixed priority (lowest index wins) and raises a one-cycle
// interrupt pulse to the jump control logic. It then tracks the handler
// until its RET instruction is decoded. After that it enforces a hold-off
// gap before the next interrupt may issue.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   irq_req     peripheral request lines, rising edge requests service
//   mask_wr     mask register write strobe
//   mask_in     new mask value (1 = source enabled)
//   ins         instruction at decode (RET = ins[19:15] == 5'b10000)
//   pc_mux_sel  jump control redirecting the PC this cycle
//   interrupt   one-cycle request pulse to jump control
//   irq_id      index of the source being serviced
//   in_service  high while the handler runs
//   pending     latched, not yet granted requests
//   mask        current mask register
// ---------------------------------------------------------------------------
module interrupt_request_ctrl #(
    parameter int               N_SRC    = 4,
    parameter int               ID_W     = 2,
    parameter int               HOLDOFF  = 2,
    parameter logic [N_SRC-1:0] MASK_RST = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_req,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_in,
    input  logic [19:0]      ins,
    input  logic             pc_mux_sel,
    output logic             interrupt,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [N_SRC-1:0]   req_q;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               interrupt_q, interrupt_d;
    logic               in_service_q, in_service_d;

    logic [N_SRC-1:0]   rise_s;
    logic [N_SRC-1:0]   eligible_s;
    logic [N_SRC-1:0]   win_onehot_s;
    logic [ID_W-1:0]    win_id_s;
    logic               go_s;
    logic               ret_s;
    logic               unused_ins_s;

    assign rise_s       = irq_req & ~req_q;
    assign eligible_s   = pending_q & mask_q;
    assign ret_s        = (ins[19:15] == 5'b10000);
    // Only the opcode field of the instruction bus matters here.
    assign unused_ins_s = ^ins[14:0];
    // A branch in flight (pc_mux_sel) defers the grant to a later cycle.
    assign go_s         = (state_q == ST_IDLE) && (|eligible_s) && !pc_mux_sel;

    // Fixed-priority arbiter: scan downwards so the lowest eligible index is kept.
    always_comb begin
        win_id_s     = {ID_W{1'b0}};
        win_onehot_s = {N_SRC{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            win_id_s     = eligible_s[i] ? ID_W'(i) : win_id_s;
            win_onehot_s = eligible_s[i] ? ({{(N_SRC-1){1'b0}}, 1'b1} << i) : win_onehot_s;
        end
    end

    // FSM state register and hold-off counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (go_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (ret_s) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = 4'(HOLDOFF);
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM output decode of the next state, so the pulses are registered.
    always_comb begin
        interrupt_d  = (state_d == ST_ISSUE);
        in_service_d = (state_d == ST_SERVICE);
    end

    // Pending, mask and grant-id next values; a same-cycle rise beats the grant clear.
    always_comb begin
        pending_d = (pending_q & ~(go_s ? win_onehot_s : {N_SRC{1'b0}})) | rise_s;
        mask_d    = mask_wr ? mask_in : mask_q;
        irq_id_d  = go_s ? win_id_s : irq_id_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q        <= {N_SRC{1'b0}};
            pending_q    <= {N_SRC{1'b0}};
            mask_q       <= MASK_RST;
            irq_id_q     <= {ID_W{1'b0}};
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            req_q        <= irq_req;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            irq_id_q     <= irq_id_d;
            interrupt_q  <= interrupt_d;
            in_service_q <= in_service_d;
        end
    end

    assign interrupt  = interrupt_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interrupt_request_ctrl
// Directed stimulus for interrupt_request_ctrl. Each expected interrupt
// (source id and the clock edge on which ISSUE is entered) is queued when
// the stimulus is applied. A monitor pops one entry per interrupt pulse.
// Level checks on pending / mask / in_service are made inline.
// ---------------------------------------------------------------------------
module tb_interrupt_request_ctrl;

    localparam logic [19:0] RET_INS = 20'h80000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_req;
    logic        mask_wr;
    logic [3:0]  mask_in;
    logic [19:0] ins;
    logic        pc_mux_sel;
    logic        interrupt;
    logic [1:0]  irq_id;
    logic        in_service;
    logic [3:0]  pending;
    logic [3:0]  mask;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int edge_n   = 0;
    int e0;

    typedef struct {
        int id;
        int edge_no;
    } exp_t;
    exp_t exp_q[$];

    interrupt_request_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_req    (irq_req),
        .mask_wr    (mask_wr),
        .mask_in    (mask_in),
        .ins        (ins),
        .pc_mux_sel (pc_mux_sel),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int id, input int edge_no);
        exp_t e;
        e.id      = id;
        e.edge_no = edge_no;
        exp_q.push_back(e);
    endtask

    // Present RET while in SERVICE, then wait out the hold-off gap back to IDLE.
    task automatic do_ret();
        ins = RET_INS;
        step(1);
        chk("ret_drop_in_service", in_service, 0);
        chk("ret_no_irq", interrupt, 0);
        ins = 20'h0;
        step(2);
    endtask

    // Scoreboard monitor: every interrupt pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && interrupt === 1'b1) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_irq: got irq_id=%0d at edge %0d, expected no interrupt", irq_id, edge_n);
            end else begin
                e = exp_q.pop_front();
                chk("irq_id", irq_id, e.id);
                chk("irq_edge", edge_n, e.edge_no);
                chk("irq_excl_in_service", in_service, 0);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        irq_req    = 4'b0000;
        mask_wr    = 1'b0;
        mask_in    = 4'b0000;
        ins        = 20'h0;
        pc_mux_sel = 1'b0;
        step(3);
        chk("rst_interrupt", interrupt, 0);
        chk("rst_irq_id", irq_id, 0);
        chk("rst_in_service", in_service, 0);
        chk("rst_pending", pending, 0);
        chk("rst_mask", mask, 4'b1111);
        reset = 1'b0;
        step(2);

        // Single request on bit 2
        e0 = edge_n;
        irq_req = 4'b0100;
        step(1);
        chk("t1_pending", pending, 4'b0100);
        chk("t1_no_irq_yet", interrupt, 0);
        push_exp(2, e0 + 2);
        step(1);
        chk("t1_interrupt", interrupt, 1);
        chk("t1_irq_id", irq_id, 2);
        chk("t1_pending_clr", pending, 0);
        chk("t1_not_in_service", in_service, 0);
        step(1);
        chk("t1_in_service", in_service, 1);
        chk("t1_pulse_end", interrupt, 0);
        chk("t1_id_stable", irq_id, 2);
        irq_req = 4'b0000;
        ins = 20'hC0012;
        step(1);
        chk("t1_nonret_stays", in_service, 1);
        do_ret();

        // Simultaneous rises on bits 3 and 1
        e0 = edge_n;
        irq_req = 4'b1010;
        push_exp(1, e0 + 2);
        push_exp(3, e0 + 7);
        step(1);
        chk("t2_pending_both", pending, 4'b1010);
        step(1);
        chk("t2_pending_after_grant", pending, 4'b1000);
        chk("t2_first_id", irq_id, 1);
        step(1);
        do_ret();
        step(1);
        step(1);
        chk("t2_second_service", in_service, 1);
        chk("t2_second_id", irq_id, 3);
        irq_req = 4'b0000;
        do_ret();

        // Masked source latches but does not issue
        mask_wr = 1'b1;
        mask_in = 4'b1110;
        step(1);
        mask_wr = 1'b0;
        chk("t3_mask_written", mask, 4'b1110);
        irq_req = 4'b0001;
        step(1);
        chk("t3_masked_pending", pending, 4'b0001);
        step(4);
        chk("t3_masked_no_irq", interrupt, 0);
        chk("t3_masked_idle", in_service, 0);
        chk("t3_still_pending", pending, 4'b0001);
        e0 = edge_n;
        mask_wr = 1'b1;
        mask_in = 4'b1111;
        push_exp(0, e0 + 2);
        step(1);
        mask_wr = 1'b0;
        chk("t3_mask_reopen", mask, 4'b1111);
        chk("t3_not_yet", interrupt, 0);
        step(1);
        chk("t3_unmasked_irq", interrupt, 1);
        step(1);
        irq_req = 4'b0000;
        do_ret();

        // Branch in flight defers the grant
        e0 = edge_n;
        irq_req = 4'b0010;
        pc_mux_sel = 1'b1;
        step(1);
        chk("t4_pending", pending, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("t4_deferred", interrupt, 0);
        end
        pc_mux_sel = 1'b0;
        push_exp(1, e0 + 5);
        step(1);
        chk("t4_issue", interrupt, 1);
        step(1);
        irq_req = 4'b0000;
        do_ret();

        // RET in IDLE is ignored; a following request keeps normal latency
        ins = RET_INS;
        step(1);
        ins = 20'h0;
        chk("t5_idle_ret_no_service", in_service, 0);
        chk("t5_idle_ret_no_irq", interrupt, 0);
        e0 = edge_n;
        irq_req = 4'b1001;
        push_exp(0, e0 + 2);
        step(1);
        chk("t5_pending", pending, 4'b1001);
        step(2);
        chk("t5_in_service", in_service, 1);
        chk("t5_pending_left", pending, 4'b1000);

        // Mask write during service, then async reset mid-cycle
        mask_wr = 1'b1;
        mask_in = 4'b0011;
        step(1);
        mask_wr = 1'b0;
        chk("t6_mask_no_abort", in_service, 1);
        chk("t6_mask_value", mask, 4'b0011);
        #2;
        reset = 1'b1;
        irq_req = 4'b1000;
        #1;
        chk("t6_async_in_service", in_service, 0);
        chk("t6_async_interrupt", interrupt, 0);
        chk("t6_async_pending", pending, 0);
        chk("t6_async_mask", mask, 4'b1111);
        chk("t6_async_irq_id", irq_id, 0);
        step(1);
        reset = 1'b0;
        e0 = edge_n;
        push_exp(3, e0 + 2);
        step(1);
        chk("t6_redetect", pending, 4'b1000);
        step(1);
        chk("t6_reissue", interrupt, 1);
        step(1);
        chk("t6_service", in_service, 1);
        irq_req = 4'b0000;
        do_ret();
        step(2);
        chk("all_irqs_seen", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
